// File: rtl/mypio_gen2.sv
// Board I/O peripheral: debounced keys with press capture, switches, LEDs and a scanned 7-segment display.
// Define MYPIO_GEN2_IRQ_EN to build the maskable press interrupt; otherwise irq is tied low.
module mypio_gen2 #(
    parameter int N_KEY       = 2,
    parameter int N_SW        = 4,
    parameter int N_LED       = 8,
    parameter int N_DIGIT     = 4,
    parameter int DEB_CYCLES  = 50000,
    parameter int SCAN_CYCLES = 50000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [2:0]           avs_address,
    input  logic                 avs_read,
    input  logic                 avs_write,
    input  logic [31:0]          avs_writedata,
    output logic [31:0]          avs_readdata,
    input  logic [N_KEY-1:0]     key,
    input  logic [N_SW-1:0]      switch,
    output logic [N_LED-1:0]     led,
    output logic [N_DIGIT+7:0]   seg_output,
    output logic                 irq
);

    localparam int DEB_W  = $clog2(DEB_CYCLES);
    localparam int SCAN_W = $clog2(SCAN_CYCLES);
    localparam int IDX_W  = (N_DIGIT > 1) ? $clog2(N_DIGIT) : 1;
    localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(SCAN_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_MAX  = IDX_W'(N_DIGIT - 1);

    localparam logic [2:0] ADDR_KEY      = 3'd0;
    localparam logic [2:0] ADDR_SW       = 3'd1;
    localparam logic [2:0] ADDR_LED      = 3'd2;
    localparam logic [2:0] ADDR_SEG_DATA = 3'd3;
    localparam logic [2:0] ADDR_SEG_CTRL = 3'd4;
    localparam logic [2:0] ADDR_EDGE     = 3'd5;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd6;

    logic                    rst_meta, rst_n;
    logic [N_KEY-1:0]        key_meta, key_sync;
    logic [N_SW-1:0]         sw_meta, sw_sync;
    logic [DEB_W-1:0]        deb_cnt [N_KEY];
    logic [N_KEY-1:0]        key_stable, press_set;
    logic [N_KEY-1:0]        edge_cap, irq_mask;
    logic [N_LED-1:0]        led_reg;
    logic [4*N_DIGIT-1:0]    seg_data;
    logic                    seg_en;
    logic [N_DIGIT-1:0]      seg_blank, seg_dp;
    logic [SCAN_W-1:0]       scan_cnt;
    logic [IDX_W-1:0]        digit_idx;
    logic [N_DIGIT+7:0]      seg_next;
    logic [31:0]             rd_mux;
    logic                    wr_led, wr_seg_data, wr_seg_ctrl, wr_edge;
    logic                    unused_wdata;

    assign unused_wdata = ^avs_writedata;

    // Reset asserts immediately but is released two clocks later, synchronous to clk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_meta <= 1'b0;
            rst_n    <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_n    <= rst_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_meta <= '1;
            key_sync <= '1;
            sw_meta  <= '0;
            sw_sync  <= '0;
        end else begin
            key_meta <= key;
            key_sync <= key_meta;
            sw_meta  <= switch;
            sw_sync  <= sw_meta;
        end
    end

    // key_stable holds the accepted level in pressed-high form.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_KEY; i++) deb_cnt[i] <= '0;
            key_stable <= '0;
        end else begin
            for (int i = 0; i < N_KEY; i++) begin
                if (~key_sync[i] == key_stable[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_MAX) begin
                    key_stable[i] <= ~key_sync[i];
                    deb_cnt[i]    <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
                end
            end
        end
    end

    always_comb begin
        press_set = '0;
        for (int i = 0; i < N_KEY; i++)
            press_set[i] = ~key_sync[i] & ~key_stable[i] & (deb_cnt[i] == DEB_MAX);
    end

    assign wr_led      = avs_write && (avs_address == ADDR_LED);
    assign wr_seg_data = avs_write && (avs_address == ADDR_SEG_DATA);
    assign wr_seg_ctrl = avs_write && (avs_address == ADDR_SEG_CTRL);
    assign wr_edge     = avs_write && (avs_address == ADDR_EDGE);

    // A new press edge wins over a simultaneous write-one-to-clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_reg   <= '0;
            seg_data  <= '0;
            seg_en    <= 1'b0;
            seg_blank <= '0;
            seg_dp    <= '0;
            edge_cap  <= '0;
        end else begin
            if (wr_led)      led_reg  <= avs_writedata[N_LED-1:0];
            if (wr_seg_data) seg_data <= avs_writedata[4*N_DIGIT-1:0];
            if (wr_seg_ctrl) begin
                seg_en    <= avs_writedata[0];
                seg_blank <= avs_writedata[N_DIGIT:1];
                seg_dp    <= avs_writedata[N_DIGIT+8:9];
            end
            edge_cap <= (edge_cap & ~(wr_edge ? avs_writedata[N_KEY-1:0] : '0)) | press_set;
        end
    end

    assign led = led_reg;

`ifdef MYPIO_GEN2_IRQ_EN
    logic wr_mask;
    assign wr_mask = avs_write && (avs_address == ADDR_IRQ_MASK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_mask <= '0;
            irq      <= 1'b0;
        end else begin
            if (wr_mask) irq_mask <= avs_writedata[N_KEY-1:0];
            irq <= |(edge_cap & irq_mask);
        end
    end
`else
    assign irq_mask = '0;
    assign irq      = 1'b0;
`endif

    always_comb begin
        rd_mux = '0;
        case (avs_address)
            ADDR_KEY:      rd_mux[N_KEY-1:0]   = key_stable;
            ADDR_SW:       rd_mux[N_SW-1:0]    = sw_sync;
            ADDR_LED:      rd_mux[N_LED-1:0]   = led_reg;
            ADDR_SEG_DATA: rd_mux[4*N_DIGIT-1:0] = seg_data;
            ADDR_SEG_CTRL: begin
                rd_mux[0]           = seg_en;
                rd_mux[N_DIGIT:1]   = seg_blank;
                rd_mux[N_DIGIT+8:9] = seg_dp;
            end
            ADDR_EDGE:     rd_mux[N_KEY-1:0]   = edge_cap;
            ADDR_IRQ_MASK: rd_mux[N_KEY-1:0]   = irq_mask;
            default:       rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        avs_readdata <= '0;
        else if (avs_read) avs_readdata <= rd_mux;
    end

    // The digit index keeps rotating even while the display is disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt  <= '0;
            digit_idx <= '0;
        end else if (scan_cnt == SCAN_MAX) begin
            scan_cnt  <= '0;
            digit_idx <= (digit_idx == IDX_MAX) ? '0 : digit_idx + IDX_W'(1);
        end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
        end
    end

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        case (h)
            4'h0: hex_to_seg = 7'h40;
            4'h1: hex_to_seg = 7'h79;
            4'h2: hex_to_seg = 7'h24;
            4'h3: hex_to_seg = 7'h30;
            4'h4: hex_to_seg = 7'h19;
            4'h5: hex_to_seg = 7'h12;
            4'h6: hex_to_seg = 7'h02;
            4'h7: hex_to_seg = 7'h78;
            4'h8: hex_to_seg = 7'h00;
            4'h9: hex_to_seg = 7'h10;
            4'hA: hex_to_seg = 7'h08;
            4'hB: hex_to_seg = 7'h03;
            4'hC: hex_to_seg = 7'h46;
            4'hD: hex_to_seg = 7'h21;
            4'hE: hex_to_seg = 7'h06;
            default: hex_to_seg = 7'h0E;
        endcase
    endfunction

    always_comb begin
        seg_next = '1;
        if (seg_en && !seg_blank[digit_idx])
            seg_next = {~(N_DIGIT'(1) << digit_idx), ~seg_dp[digit_idx],
                        hex_to_seg(seg_data[{digit_idx, 2'b00} +: 4])};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) seg_output <= '1;
        else        seg_output <= seg_next;
    end

endmodule

// File: tb/tb_mypio_gen2.sv
// Self-checking bench for mypio_gen2: register table, debounce/edge/irq sequences, scanner and reset.
module tb_mypio_gen2;

    localparam int N_KEY = 2, N_SW = 4, N_LED = 8, N_DIGIT = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  avs_address;
    logic        avs_read, avs_write;
    logic [31:0] avs_writedata, avs_readdata;
    logic [N_KEY-1:0]   key;
    logic [N_SW-1:0]    switch;
    logic [N_LED-1:0]   led;
    logic [N_DIGIT+7:0] seg_output;
    logic        irq;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } vec_t;
    vec_t vecs[12];

`ifdef MYPIO_GEN2_IRQ_EN
    localparam logic IRQ_BUILT = 1'b1;
`else
    localparam logic IRQ_BUILT = 1'b0;
`endif

    mypio_gen2 #(
        .N_KEY(N_KEY), .N_SW(N_SW), .N_LED(N_LED), .N_DIGIT(N_DIGIT),
        .DEB_CYCLES(16), .SCAN_CYCLES(4)
    ) u_dut (
        .clk(clk), .reset_n(reset_n),
        .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
        .key(key), .switch(switch), .led(led), .seg_output(seg_output), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
        avs_address   = addr;
        avs_writedata = data;
        avs_write     = 1'b1;
        @(negedge clk);
        avs_write     = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] addr, input logic [31:0] expected, input string name);
        logic [31:0] e;
        string n;
        avs_address = addr;
        avs_read    = 1'b1;
        exp_q.push_back(expected);
        name_q.push_back(name);
        @(negedge clk);
        avs_read = 1'b0;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        checkOutput(n, avs_readdata, e);
    endtask

    task automatic applyStimulus(input vec_t v);
        bus_write(v.addr, v.wdata);
        bus_read(v.addr, v.exp, v.name);
    endtask

    task automatic wait_for_seg(input logic [11:0] value, input string name);
        for (int i = 0; i < 40 && seg_output !== value; i++) @(negedge clk);
        checkOutput(name, 32'(seg_output), 32'(value));
    endtask

    initial begin
        logic [11:0] all_off;

        vecs[0]  = '{3'd2, 32'h000000A5, 32'h000000A5, "led_a5"};
        vecs[1]  = '{3'd2, 32'hFFFFFF3C, 32'h0000003C, "led_trunc"};
        vecs[2]  = '{3'd3, 32'hDEADBEEF, 32'h0000BEEF, "segdata_trunc"};
        vecs[3]  = '{3'd3, 32'h00001234, 32'h00001234, "segdata_1234"};
        vecs[4]  = '{3'd4, 32'hFFFFFFFF, 32'h00001E1F, "segctrl_ones"};
        vecs[5]  = '{3'd4, 32'h00000000, 32'h00000000, "segctrl_zero"};
        vecs[6]  = '{3'd0, 32'h000000FF, 32'h00000000, "key_ro"};
        vecs[7]  = '{3'd1, 32'h00000000, 32'h0000000A, "sw_sync"};
        vecs[8]  = '{3'd7, 32'hFFFFFFFF, 32'h00000000, "addr7_zero"};
        vecs[9]  = '{3'd6, 32'hFFFFFFFF, IRQ_BUILT ? 32'h3 : 32'h0, "mask_ones"};
        vecs[10] = '{3'd6, 32'h00000001, IRQ_BUILT ? 32'h1 : 32'h0, "mask_key0"};
        vecs[11] = '{3'd5, 32'h00000003, 32'h00000000, "edge_empty"};

        reset_n = 1'b0;
        avs_address = '0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
        key = '1;
        switch = 4'hA;
        repeat (3) @(negedge clk);
        checkOutput("reset_led", 32'(led), 32'h0);
        checkOutput("reset_seg", 32'(seg_output), 32'hFFF);
        checkOutput("reset_irq", 32'(irq), 32'h0);
        checkOutput("reset_readdata", avs_readdata, 32'h0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i]);
            if (vecs[i].addr == 3'd2) checkOutput("led_port", 32'(led), vecs[i].exp);
        end

        // Read and write to the same register in one cycle returns the old value.
        avs_address = 3'd2; avs_writedata = 32'h11; avs_write = 1'b1; avs_read = 1'b1;
        exp_q.push_back(32'h3C);
        name_q.push_back("rw_same_cycle");
        @(negedge clk);
        avs_write = 1'b0; avs_read = 1'b0;
        checkOutput(name_q.pop_front(), avs_readdata, exp_q.pop_front());
        checkOutput("led_after_rw", 32'(led), 32'h11);

        // key[0] low 20 cycles; a W1C lands on the exact cycle the press is accepted.
        key[0] = 1'b0;
        repeat (17) @(negedge clk);
        bus_write(3'd5, 32'h1);
        bus_read(3'd0, 32'h1, "key0_pressed");
        bus_read(3'd5, 32'h1, "edge_set_wins");
        checkOutput("irq_on_press", 32'(irq), 32'(IRQ_BUILT));
        key[0] = 1'b1;
        repeat (30) @(negedge clk);
        bus_read(3'd0, 32'h0, "key0_released");
        bus_read(3'd5, 32'h1, "edge_no_release");
        bus_write(3'd5, 32'h1);
        @(negedge clk);
        checkOutput("irq_cleared", 32'(irq), 32'h0);
        bus_read(3'd5, 32'h0, "edge_w1c");

        for (int i = 0; i < 20; i++) begin
            key[1] = ~key[1];
            repeat (5) @(negedge clk);
        end
        repeat (20) @(negedge clk);
        bus_read(3'd0, 32'h0, "bounce_key");
        bus_read(3'd5, 32'h0, "bounce_edge");

        bus_write(3'd3, 32'h1234);
        bus_write(3'd4, 32'h1);
        wait_for_seg(12'hE99, "scan_d0");
        repeat (4) @(negedge clk);
        checkOutput("scan_d1", 32'(seg_output), 32'hDB0);
        repeat (4) @(negedge clk);
        checkOutput("scan_d2", 32'(seg_output), 32'hBA4);
        repeat (4) @(negedge clk);
        checkOutput("scan_d3", 32'(seg_output), 32'h7F9);
        repeat (4) @(negedge clk);
        checkOutput("scan_wrap", 32'(seg_output), 32'hE99);

        bus_write(3'd4, 32'h201);
        wait_for_seg(12'hE19, "scan_dp0");
        bus_write(3'd4, 32'h5);
        wait_for_seg(12'hE99, "scan_pre_blank");
        repeat (4) @(negedge clk);
        checkOutput("scan_blank_d1", 32'(seg_output), 32'hFFF);
        repeat (4) @(negedge clk);
        checkOutput("scan_after_blank", 32'(seg_output), 32'hBA4);

        bus_write(3'd4, 32'h0);
        @(negedge clk);
        all_off = '1;
        for (int i = 0; i < 8; i++) begin
            all_off &= seg_output;
            @(negedge clk);
        end
        checkOutput("scan_disabled", 32'(all_off), 32'hFFF);

        // Asynchronous reset mid-debounce with everything active.
        bus_write(3'd2, 32'hFF);
        bus_write(3'd4, 32'h1);
        bus_read(3'd2, 32'hFF, "led_ff");
        key[0] = 1'b0;
        repeat (8) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("midreset_led", 32'(led), 32'h0);
        checkOutput("midreset_seg", 32'(seg_output), 32'hFFF);
        checkOutput("midreset_irq", 32'(irq), 32'h0);
        checkOutput("midreset_readdata", avs_readdata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        key[0] = 1'b1;
        repeat (30) @(negedge clk);
        bus_read(3'd0, 32'h0, "post_reset_key");
        bus_read(3'd5, 32'h0, "post_reset_edge");
        bus_read(3'd2, 32'h0, "post_reset_led");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
